// File: rtl/id_ex_ctrl_pipe_if.sv
// ID/EX control-path bus: decoder bundle and squash/hold requests in, registered
// EX bundle plus hazard/stall feedback out.
interface id_ex_ctrl_pipe_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [1:0]       id_AluOP_MD;
   logic             id_memWrite;
   logic             id_regWrite;
   logic             id_regDest;
   logic             id_aluSrc;
   logic             id_memtoReg;
   logic             id_Branch;
   logic             id_jump;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic [4:0]       id_rd;
   logic             flush_i;
   logic             ex_hold_i;

   logic [1:0]       ex_AluOP_MD;
   logic             ex_memWrite;
   logic             ex_regWrite;
   logic             ex_regDest;
   logic             ex_aluSrc;
   logic             ex_memtoReg;
   logic             ex_Branch;
   logic             ex_jump;
   logic [4:0]       ex_rs;
   logic [4:0]       ex_rt;
   logic [4:0]       ex_rd;
   logic             ex_valid;
   logic             hazard_o;
   logic             stall_o;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output id_valid, id_AluOP_MD, id_memWrite, id_regWrite, id_regDest, id_aluSrc,
             id_memtoReg, id_Branch, id_jump, id_rs, id_rt, id_rd, flush_i, ex_hold_i,
      input  ex_AluOP_MD, ex_memWrite, ex_regWrite, ex_regDest, ex_aluSrc, ex_memtoReg,
             ex_Branch, ex_jump, ex_rs, ex_rt, ex_rd, ex_valid, hazard_o, stall_o, bubble_cnt
   );

   modport slave (
      input  id_valid, id_AluOP_MD, id_memWrite, id_regWrite, id_regDest, id_aluSrc,
             id_memtoReg, id_Branch, id_jump, id_rs, id_rt, id_rd, flush_i, ex_hold_i,
      output ex_AluOP_MD, ex_memWrite, ex_regWrite, ex_regDest, ex_aluSrc, ex_memtoReg,
             ex_Branch, ex_jump, ex_rs, ex_rt, ex_rd, ex_valid, hazard_o, stall_o, bubble_cnt
   );
endinterface

// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX control pipeline register with load-use bubbles, EX hold and flush squash.
// Optional macro ID_EX_BUBBLE_CNT_EN enables the saturating hazard/flush bubble counter.
module id_ex_ctrl_pipe #(
   parameter int FLUSH_DEPTH = 1,
   parameter int CNT_W       = 16
) (
   input logic              clk,
   input logic              rst_n,
   id_ex_ctrl_pipe_if.slave bus
);

   typedef enum logic [1:0] {RUN, HOLD, FLUSH} pipeState_e;

   typedef struct packed {
      logic       valid;
      logic [1:0] aluOp;
      logic       memWrite;
      logic       regWrite;
      logic       regDest;
      logic       aluSrc;
      logic       memtoReg;
      logic       branch;
      logic       jump;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } exBundle_t;

   pipeState_e state, stateNext;
   exBundle_t  exReg, exNext, idLoad;
   logic [2:0] flushCnt, cntNext;
   logic       hazard;
   logic       countBubble;

   // A bubble is a hard constant so X on id_* while id_valid=0 never reaches EX.
   assign idLoad = bus.id_valid
      ? '{valid: 1'b1, aluOp: bus.id_AluOP_MD, memWrite: bus.id_memWrite,
          regWrite: bus.id_regWrite, regDest: bus.id_regDest, aluSrc: bus.id_aluSrc,
          memtoReg: bus.id_memtoReg, branch: bus.id_Branch, jump: bus.id_jump,
          rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd}
      : '0;

   assign hazard = (state == RUN) & exReg.valid & exReg.memtoReg & exReg.regWrite
                 & (exReg.rt != 5'd0) & bus.id_valid
                 & ((exReg.rt == bus.id_rs)
                    | ((exReg.rt == bus.id_rt) & (~bus.id_aluSrc | bus.id_memWrite)));

   assign bus.hazard_o = hazard;
   assign bus.stall_o  = (hazard | bus.ex_hold_i) & ~bus.flush_i & (state != FLUSH);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      stateNext   = state;
      cntNext     = flushCnt;
      exNext      = exReg;
      countBubble = 1'b0;
      if (bus.flush_i) begin
         exNext      = '0;
         cntNext     = 3'(FLUSH_DEPTH - 1);
         stateNext   = (FLUSH_DEPTH == 1) ? RUN : FLUSH;
         countBubble = 1'b1;
      end else begin
         unique case (state)
            FLUSH: begin
               exNext      = '0;
               countBubble = 1'b1;
               cntNext     = (flushCnt == 3'd0) ? 3'd0 : flushCnt - 3'd1;
               // The counter reaching zero on this edge ends the squash window.
               if (flushCnt <= 3'd1) stateNext = RUN;
            end
            HOLD: begin
               if (!bus.ex_hold_i) begin
                  stateNext = RUN;
                  exNext    = idLoad;
               end
            end
            default: begin
               if (bus.ex_hold_i) begin
                  stateNext = HOLD;
               end else if (hazard) begin
                  exNext      = '0;
                  countBubble = 1'b1;
               end else begin
                  exNext = idLoad;
               end
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RUN;
         flushCnt <= 3'd0;
         exReg    <= '0;
      end else begin
         state    <= stateNext;
         flushCnt <= cntNext;
         exReg    <= exNext;
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [CNT_W-1:0] bubbleCnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bubbleCnt <= '0;
      end else if (countBubble && (bubbleCnt != {CNT_W{1'b1}})) begin
         bubbleCnt <= bubbleCnt + 1'b1;
      end
   end

   assign bus.bubble_cnt = bubbleCnt;
`else
   logic unusedCount;
   assign unusedCount    = countBubble;
   assign bus.bubble_cnt = {CNT_W{1'b0}};
`endif

   assign bus.ex_valid    = exReg.valid;
   assign bus.ex_AluOP_MD = exReg.aluOp;
   assign bus.ex_memWrite = exReg.memWrite;
   assign bus.ex_regWrite = exReg.regWrite;
   assign bus.ex_regDest  = exReg.regDest;
   assign bus.ex_aluSrc   = exReg.aluSrc;
   assign bus.ex_memtoReg = exReg.memtoReg;
   assign bus.ex_Branch   = exReg.branch;
   assign bus.ex_jump     = exReg.jump;
   assign bus.ex_rs       = exReg.rs;
   assign bus.ex_rt       = exReg.rt;
   assign bus.ex_rd       = exReg.rd;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Directed scoreboard bench for id_ex_ctrl_pipe (FLUSH_DEPTH=2, CNT_W=4).
module tb_id_ex_ctrl_pipe;

   localparam int FLUSH_DEPTH = 2;
   localparam int CNT_W       = 4;

   typedef struct packed {
      logic       valid;
      logic [1:0] aluOp;
      logic       memWrite;
      logic       regWrite;
      logic       regDest;
      logic       aluSrc;
      logic       memtoReg;
      logic       branch;
      logic       jump;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   bubbleModel = 0;
   exp_t sbq[$];

   id_ex_ctrl_pipe_if #(.CNT_W(CNT_W)) bus ();

   id_ex_ctrl_pipe #(.FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t mk(input logic [1:0] alu, input logic mw, input logic rw,
                               input logic rdst, input logic asrc, input logic m2r,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd);
      exp_t e;
      e = '0;
      e.valid = 1'b1; e.aluOp = alu; e.memWrite = mw; e.regWrite = rw; e.regDest = rdst;
      e.aluSrc = asrc; e.memtoReg = m2r; e.rs = rs; e.rt = rt; e.rd = rd;
      return e;
   endfunction

   function automatic exp_t observed();
      return {bus.ex_valid, bus.ex_AluOP_MD, bus.ex_memWrite, bus.ex_regWrite, bus.ex_regDest,
              bus.ex_aluSrc, bus.ex_memtoReg, bus.ex_Branch, bus.ex_jump,
              bus.ex_rs, bus.ex_rt, bus.ex_rd};
   endfunction

   function automatic int expCnt();
`ifdef ID_EX_BUBBLE_CNT_EN
      return (bubbleModel > 15) ? 15 : bubbleModel;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic driveId(input exp_t b, input logic flush, input logic hold);
      bus.id_valid    = b.valid;
      bus.id_AluOP_MD = b.aluOp;
      bus.id_memWrite = b.memWrite;
      bus.id_regWrite = b.regWrite;
      bus.id_regDest  = b.regDest;
      bus.id_aluSrc   = b.aluSrc;
      bus.id_memtoReg = b.memtoReg;
      bus.id_Branch   = b.branch;
      bus.id_jump     = b.jump;
      bus.id_rs       = b.rs;
      bus.id_rt       = b.rt;
      bus.id_rd       = b.rd;
      bus.flush_i     = flush;
      bus.ex_hold_i   = hold;
      #1;
   endtask

   // Push the EX content expected after the next edge, clock, then compare.
   task automatic tick(input string tag, input exp_t e);
      exp_t want;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         check({tag, "_underflow"}, 32'd0, 32'd1);
      end else begin
         want = sbq.pop_front();
         check(tag, 32'(observed()), 32'(want));
      end
   endtask

   initial begin
      exp_t lw8, add8, lw0, add0, lw5, sw5, addi5, addA, addB, addC, lw7, dep7;
      lw8   = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 5'd8, 5'd0);
      add8  = mk(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 5'd9, 5'd10);
      lw0   = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
      add0  = mk(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd11);
      lw5   = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd5, 5'd0);
      sw5   = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0);
      addi5 = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd5, 5'd0);
      addA  = mk(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 5'd13, 5'd14);
      addB  = mk(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd15, 5'd16, 5'd17);
      addC  = mk(2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd18, 5'd19, 5'd20);
      lw7   = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 5'd7, 5'd0);
      dep7  = mk(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd1, 5'd21);
      addA.branch = 1'b1;
      addC.jump   = 1'b1;

      // Reset dominates a valid regWrite instruction in ID.
      rst_n = 1'b0;
      driveId(add8, 1'b0, 1'b0);
      tick("reset_edge1", '0);
      tick("reset_edge2", '0);
      check("reset_stall", 32'(bus.stall_o), 32'd0);
      check("reset_cnt", 32'(bus.bubble_cnt), 32'd0);

      // First edge after release loads the ID bundle.
      rst_n = 1'b1;
      driveId(lw8, 1'b0, 1'b0);
      check("lw_hazard_idle", 32'(bus.hazard_o), 32'd0);
      tick("lw_pass", lw8);

      // Load-use on rs: one bubble, then the dependent instruction.
      driveId(add8, 1'b0, 1'b0);
      check("lu_hazard", 32'(bus.hazard_o), 32'd1);
      check("lu_stall", 32'(bus.stall_o), 32'd1);
      bubbleModel++;
      tick("lu_bubble", '0);
      check("lu_hazard_clear", 32'(bus.hazard_o), 32'd0);
      tick("lu_dep_load", add8);

      // rt = $zero never creates a hazard.
      driveId(lw0, 1'b0, 1'b0);
      tick("lw0_load", lw0);
      driveId(add0, 1'b0, 1'b0);
      check("zero_hazard", 32'(bus.hazard_o), 32'd0);
      check("zero_stall", 32'(bus.stall_o), 32'd0);
      tick("zero_load", add0);

      // rt dependence counts for stores but not for immediate ops.
      driveId(lw5, 1'b0, 1'b0);
      tick("lw5_load", lw5);
      driveId(sw5, 1'b0, 1'b0);
      check("sw_hazard", 32'(bus.hazard_o), 32'd1);
      driveId(addi5, 1'b0, 1'b0);
      check("addi_hazard", 32'(bus.hazard_o), 32'd0);
      tick("addi_load", addi5);

      // Single-cycle flush: exactly two bubbles with id_valid held.
      driveId(addA, 1'b1, 1'b0);
      check("flush_stall", 32'(bus.stall_o), 32'd0);
      bubbleModel++;
      tick("flush_b1", '0);
      driveId(addA, 1'b0, 1'b0);
      check("flushst_stall", 32'(bus.stall_o), 32'd0);
      bubbleModel++;
      tick("flush_b2", '0);
      tick("flush_reload", addA);
      check("cnt_lu_flush", 32'(bus.bubble_cnt), 32'(expCnt()));

      // Hold freezes EX; flush on the third hold cycle discards it.
      driveId(addB, 1'b0, 1'b1);
      check("hold_stall1", 32'(bus.stall_o), 32'd1);
      tick("hold_1", addA);
      check("hold_stall2", 32'(bus.stall_o), 32'd1);
      tick("hold_2", addA);
      driveId(addB, 1'b1, 1'b1);
      check("holdflush_stall", 32'(bus.stall_o), 32'd0);
      bubbleModel++;
      tick("holdflush_b1", '0);
      driveId(addB, 1'b0, 1'b0);
      bubbleModel++;
      tick("holdflush_b2", '0);
      tick("holdflush_reload", addB);
      check("cnt_holdflush", 32'(bus.bubble_cnt), 32'(expCnt()));

      // Leaving HOLD performs a normal load on the same edge.
      driveId(addC, 1'b0, 1'b1);
      tick("hold_short", addB);
      driveId(addC, 1'b0, 1'b0);
      tick("hold_exit_load", addC);

      // Hold beats hazard; detection is suppressed while in HOLD.
      driveId(lw7, 1'b0, 1'b0);
      tick("lw7_load", lw7);
      driveId(dep7, 1'b0, 1'b1);
      check("run_hold_hazard", 32'(bus.hazard_o), 32'd1);
      tick("hold_over_hazard", lw7);
      check("hold_hazard_off", 32'(bus.hazard_o), 32'd0);
      check("hold_stall3", 32'(bus.stall_o), 32'd1);

      // Bubble stays all-zero with X on id_* while id_valid=0.
      driveId('0, 1'b0, 1'b0);
      bus.id_AluOP_MD = 'x; bus.id_regWrite = 'x; bus.id_memtoReg = 'x;
      bus.id_rs = 'x; bus.id_rt = 'x; bus.id_rd = 'x;
      #1;
      check("x_stall", 32'(bus.stall_o), 32'd0);
      tick("x_bubble", '0);
      check("x_cnt_unchanged", 32'(bus.bubble_cnt), 32'(expCnt()));

      // Long flush saturates the counter.
      driveId(addA, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         bubbleModel++;
         tick("long_flush", '0);
      end
      driveId(addA, 1'b0, 1'b0);
      bubbleModel++;
      tick("long_flush_tail", '0);
      tick("long_flush_reload", addA);
      check("cnt_saturate", 32'(bus.bubble_cnt), 32'(expCnt()));

      rst_n = 1'b0;
      tick("final_reset", '0);
      check("cnt_reset", 32'(bus.bubble_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
